// File: rtl/fifo_drain_pkg.sv
// Shared constants and types for the FIFO drain DMA engine:
// CSR word map, CTRL/STATUS bit positions and FSM states.
package fifo_drain_pkg;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_BASE      = 3'd1;
  localparam logic [2:0] ADDR_LENGTH    = 3'd2;
  localparam logic [2:0] ADDR_WR_PTR    = 3'd3;
  localparam logic [2:0] ADDR_RD_PTR    = 3'd4;
  localparam logic [2:0] ADDR_STATUS    = 3'd5;
  localparam logic [2:0] ADDR_THRESHOLD = 3'd6;
  localparam logic [2:0] ADDR_COUNT     = 3'd7;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  localparam int STATUS_BUSY      = 0;
  localparam int STATUS_FULL      = 1;
  localparam int STATUS_IRQ       = 2;
  localparam int STATUS_USEDW_LSB = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_drain_csr.sv
// CSR slave for the drain engine: register file, producer pointer and word
// counter, soft clear, W1C interrupt status and the registered irq line.
module fifo_drain_csr
  import fifo_drain_pkg::*;
#(
  parameter int FIFO_USEDW_WIDTH = 8,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  address,
  input  logic                        write,
  input  logic                        read,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        irq,
  input  logic                        busy,
  input  logic                        word_done,
  input  logic [FIFO_USEDW_WIDTH-1:0] usedw,
  output logic                        enable,
  output logic [31:0]                 base,
  output logic [LEN_WIDTH-1:0]        length,
  output logic [LEN_WIDTH-1:0]        wr_ptr,
  output logic                        buf_full,
  output logic                        clear_block
);

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  logic                 irq_en;
  logic                 irq_pending;
  logic                 clear_pending;
  logic [LEN_WIDTH-1:0] rd_ptr;
  logic [LEN_WIDTH-1:0] threshold;
  logic [LEN_WIDTH-1:0] count;
  logic [LEN_WIDTH-1:0] wr_ptr_inc;
  logic [LEN_WIDTH-1:0] wr_ptr_succ;
  logic [LEN_WIDTH-1:0] count_inc;
  logic                 clear_req;
  logic                 apply_clear;
  logic                 w1c;
  logic [31:0]          read_next;

  assign wr_ptr_inc  = wr_ptr + ONE;
  assign wr_ptr_succ = (wr_ptr_inc == length) ? '0 : wr_ptr_inc;
  assign buf_full    = (wr_ptr_succ == rd_ptr);
  assign count_inc   = (&count) ? count : count + ONE;

  assign clear_req   = write && (address == ADDR_CTRL) && writedata[CTRL_CLEAR];
  assign w1c         = write && (address == ADDR_STATUS) && writedata[STATUS_IRQ];
  // A clear requested mid-word waits until the engine is back in IDLE.
  assign apply_clear = (clear_req || clear_pending) && !busy;
  assign clear_block = clear_req || clear_pending;

  always_comb begin
    read_next = '0;
    case (address)
      ADDR_CTRL: begin
        read_next[CTRL_ENABLE] = enable;
        read_next[CTRL_IRQ_EN] = irq_en;
      end
      ADDR_BASE:      read_next = base;
      ADDR_LENGTH:    read_next[LEN_WIDTH-1:0] = length;
      ADDR_WR_PTR:    read_next[LEN_WIDTH-1:0] = wr_ptr;
      ADDR_RD_PTR:    read_next[LEN_WIDTH-1:0] = rd_ptr;
      ADDR_STATUS: begin
        read_next[STATUS_BUSY] = busy;
        read_next[STATUS_FULL] = buf_full;
        read_next[STATUS_IRQ]  = irq_pending;
        read_next[STATUS_USEDW_LSB +: FIFO_USEDW_WIDTH] = usedw;
      end
      ADDR_THRESHOLD: read_next[LEN_WIDTH-1:0] = threshold;
      ADDR_COUNT:     read_next[LEN_WIDTH-1:0] = count;
      default:        read_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable        <= 1'b0;
      irq_en        <= 1'b0;
      base          <= '0;
      length        <= '0;
      rd_ptr        <= '0;
      threshold     <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      irq_pending   <= 1'b0;
      clear_pending <= 1'b0;
      irq           <= 1'b0;
      readdata      <= '0;
    end else begin
      if (write) begin
        case (address)
          ADDR_CTRL: begin
            enable <= writedata[CTRL_ENABLE];
            irq_en <= writedata[CTRL_IRQ_EN];
          end
          ADDR_BASE:      base      <= {writedata[31:2], 2'b00};
          ADDR_LENGTH:    length    <= writedata[LEN_WIDTH-1:0];
          ADDR_RD_PTR:    rd_ptr    <= writedata[LEN_WIDTH-1:0];
          ADDR_THRESHOLD: threshold <= writedata[LEN_WIDTH-1:0];
          default: ;
        endcase
      end

      if (apply_clear) begin
        clear_pending <= 1'b0;
      end else if (clear_req) begin
        clear_pending <= 1'b1;
      end

      if (apply_clear) begin
        wr_ptr <= '0;
      end else if (word_done) begin
        wr_ptr <= wr_ptr_succ;
      end

      // A W1C colliding with an increment counts only the new word.
      if (apply_clear) begin
        count       <= '0;
        irq_pending <= 1'b0;
      end else if (w1c) begin
        count       <= word_done ? ONE : '0;
        irq_pending <= word_done && (threshold != '0) && (threshold <= ONE);
      end else if (word_done) begin
        count <= count_inc;
        if ((threshold != '0) && (count_inc >= threshold)) begin
          irq_pending <= 1'b1;
        end
      end

      irq <= irq_pending & irq_en;

      if (read) begin
        readdata <= read_next;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_dma.sv
// Drains a non-show-ahead FIFO into a circular buffer in system memory,
// one Avalon-MM master write per word, controlled through fifo_drain_csr.
module fifo_drain_dma
  import fifo_drain_pkg::*;
#(
  parameter int FIFO_WIDTH       = 16,
  parameter int FIFO_USEDW_WIDTH = 8,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  avs_csr_address,
  input  logic                        avs_csr_write,
  input  logic                        avs_csr_read,
  input  logic [31:0]                 avs_csr_writedata,
  output logic [31:0]                 avs_csr_readdata,
  output logic                        avs_csr_irq,
  output logic                        fifo_rdreq,
  input  logic [FIFO_WIDTH-1:0]       fifo_q,
  input  logic                        fifo_rdempty,
  input  logic [FIFO_USEDW_WIDTH-1:0] fifo_rdusedw,
  output logic [31:0]                 avm_address,
  output logic                        avm_write,
  output logic [31:0]                 avm_writedata,
  output logic [3:0]                  avm_byteenable,
  input  logic                        avm_waitrequest
);

  state_t               state_reg;
  state_t               state_next;
  logic                 enable;
  logic                 buf_full;
  logic                 clear_block;
  logic                 busy;
  logic                 word_done;
  logic [31:0]          base;
  logic [LEN_WIDTH-1:0] length;
  logic [LEN_WIDTH-1:0] wr_ptr;

  assign busy           = (state_reg != IDLE);
  assign word_done      = (state_reg == WRITE) && !avm_waitrequest;
  assign avm_byteenable = 4'hF;

  fifo_drain_csr #(
    .FIFO_USEDW_WIDTH(FIFO_USEDW_WIDTH),
    .LEN_WIDTH       (LEN_WIDTH)
  ) u_csr (
    .clk        (clk),
    .reset      (reset),
    .address    (avs_csr_address),
    .write      (avs_csr_write),
    .read       (avs_csr_read),
    .writedata  (avs_csr_writedata),
    .readdata   (avs_csr_readdata),
    .irq        (avs_csr_irq),
    .busy       (busy),
    .word_done  (word_done),
    .usedw      (fifo_rdusedw),
    .enable     (enable),
    .base       (base),
    .length     (length),
    .wr_ptr     (wr_ptr),
    .buf_full   (buf_full),
    .clear_block(clear_block)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (enable && !fifo_rdempty && !buf_full && (length != '0) && !clear_block) begin
          state_next = POP;
        end
      end
      POP:     state_next = CAPTURE;
      CAPTURE: state_next = WRITE;
      WRITE: begin
        if (!avm_waitrequest) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_rdreq = (state_reg == POP);
    avm_write  = (state_reg == WRITE);
  end

  // Address and data are frozen at CAPTURE so they stay stable through stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avm_address   <= '0;
      avm_writedata <= '0;
    end else if (state_reg == CAPTURE) begin
      avm_address   <= base + 32'({wr_ptr, 2'b00});
      avm_writedata <= 32'(fifo_q);
    end
  end

endmodule

// File: tb/tb_fifo_drain_dma.sv
// Randomized self-checking bench for fifo_drain_dma: FIFO and memory slave
// models plus a circular-buffer reference model of the expected writes.
module tb_fifo_drain_dma;

  localparam int FW = 16;
  localparam int UW = 8;
  localparam int LW = 16;

  localparam logic [2:0] A_CTRL = 3'd0, A_BASE = 3'd1, A_LENGTH = 3'd2, A_WR_PTR = 3'd3;
  localparam logic [2:0] A_RD_PTR = 3'd4, A_STATUS = 3'd5, A_THRESHOLD = 3'd6, A_COUNT = 3'd7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    avs_csr_address = '0;
  logic          avs_csr_write = 1'b0;
  logic          avs_csr_read = 1'b0;
  logic [31:0]   avs_csr_writedata = '0;
  logic [31:0]   avs_csr_readdata;
  logic          avs_csr_irq;
  logic          fifo_rdreq;
  logic [FW-1:0] fifo_q = '0;
  logic          fifo_rdempty = 1'b1;
  logic [UW-1:0] fifo_rdusedw = '0;
  logic [31:0]   avm_address;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic          avm_waitrequest;

  int checks = 0;
  int errors = 0;

  bit force_wait = 1'b0;
  bit rand_wait = 1'b0;
  bit rand_stall = 1'b0;

  logic [FW-1:0] fifo_mem[$];
  logic [63:0]   act_q[$];
  logic [63:0]   exp_q[$];

  // Reference model of software-visible state
  logic [FW-1:0] m_pend[$];
  logic [31:0]   m_base = '0;
  int            m_len = 0, m_wr = 0, m_rd = 0, m_count = 0, m_thr = 0;
  bit            m_en = 1'b0, m_irq = 1'b0;

  fifo_drain_dma #(.FIFO_WIDTH(FW), .FIFO_USEDW_WIDTH(UW), .LEN_WIDTH(LW)) dut (
    .clk              (clk),
    .reset            (reset),
    .avs_csr_address  (avs_csr_address),
    .avs_csr_write    (avs_csr_write),
    .avs_csr_read     (avs_csr_read),
    .avs_csr_writedata(avs_csr_writedata),
    .avs_csr_readdata (avs_csr_readdata),
    .avs_csr_irq      (avs_csr_irq),
    .fifo_rdreq       (fifo_rdreq),
    .fifo_q           (fifo_q),
    .fifo_rdempty     (fifo_rdempty),
    .fifo_rdusedw     (fifo_rdusedw),
    .avm_address      (avm_address),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (avm_waitrequest)
  );

  always #5 clk = ~clk;

  assign avm_waitrequest = force_wait | rand_stall;

  always @(negedge clk) rand_stall <= rand_wait && ($urandom_range(0, 2) == 0);

  // Non-show-ahead FIFO: data appears the cycle after the pop request.
  always @(posedge clk) begin
    if (fifo_rdreq && fifo_mem.size() > 0) fifo_q <= fifo_mem.pop_front();
    fifo_rdempty <= (fifo_mem.size() == 0);
    fifo_rdusedw <= UW'(fifo_mem.size());
  end

  always @(posedge clk) begin
    if (avm_write && !avm_waitrequest) act_q.push_back({avm_address, avm_writedata});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_csr_address = a;
    avs_csr_writedata = d;
    avs_csr_write = 1'b1;
    @(negedge clk);
    avs_csr_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_csr_address = a;
    avs_csr_read = 1'b1;
    @(negedge clk);
    avs_csr_read = 1'b0;
    d = avs_csr_readdata;
  endtask

  task automatic push_word(input logic [FW-1:0] d);
    fifo_mem.push_back(d);
    m_pend.push_back(d);
  endtask

  // Each word goes to slot m_wr; the ring holds at most LENGTH-1 unread words.
  task automatic model_drain(input int max_words);
    int n = 0;
    while (m_en && m_len != 0 && m_pend.size() > 0 && n < max_words &&
           ((m_wr + 1) % m_len) != m_rd) begin
      exp_q.push_back({m_base + 32'(4 * m_wr), 16'h0, m_pend.pop_front()});
      m_wr = (m_wr + 1) % m_len;
      if (m_count < 65535) m_count++;
      if (m_thr != 0 && m_count >= m_thr) m_irq = 1'b1;
      n++;
    end
  endtask

  task automatic wait_writes();
    int n = 0;
    while (act_q.size() < exp_q.size() && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_write_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      ok = avm_write;
    end
  endtask

  task automatic soft_clear();
    csr_write(A_CTRL, 32'h4);
    m_en = 1'b0;
    m_wr = 0;
    m_count = 0;
    m_irq = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (avm_write !== 1'b0 || fifo_rdreq !== 1'b0 || avs_csr_irq !== 1'b0 ||
        avm_address !== 32'h0 || avm_writedata !== 32'h0 || avs_csr_readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got write=%b rdreq=%b irq=%b addr=%h data=%h rd=%h want all 0",
               avm_write, fifo_rdreq, avs_csr_irq, avm_address, avm_writedata, avs_csr_readdata);
    end
    checks++;
    if (avm_byteenable !== 4'hF) begin
      errors++;
      $display("FAIL reset_byteenable got %h want f", avm_byteenable);
    end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      csr_read(3'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_csr%0d got %h want 0", a, d);
      end
    end
  endtask

  task automatic test_basic_drain();
    logic [31:0] d;
    csr_write(A_BASE, 32'h1000);   m_base = 32'h1000;
    csr_write(A_LENGTH, 32'd8);    m_len = 8;
    csr_write(A_RD_PTR, 32'd0);    m_rd = 0;
    csr_write(A_CTRL, 32'h1);      m_en = 1'b1;
    push_word(16'h00A1);
    push_word(16'h00A2);
    push_word(16'h00A3);
    model_drain(100);
    wait_writes();
    checks++;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_write%0d got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
    csr_read(A_WR_PTR, d);
    checks++;
    if (d !== 32'(m_wr)) begin errors++; $display("FAIL basic_wr_ptr got %0d want %0d", d, m_wr); end
    csr_read(A_COUNT, d);
    checks++;
    if (d !== 32'(m_count)) begin errors++; $display("FAIL basic_count_reg got %0d want %0d", d, m_count); end
  endtask

  task automatic test_wrap_full();
    logic [31:0] d;
    soft_clear();
    csr_write(A_BASE, 32'h0);     m_base = 32'h0;
    csr_write(A_LENGTH, 32'd4);   m_len = 4;
    csr_write(A_RD_PTR, 32'd0);   m_rd = 0;
    csr_write(A_CTRL, 32'h1);     m_en = 1'b1;
    for (int i = 0; i < 5; i++) push_word(FW'($urandom));
    model_drain(100);
    wait_writes();
    checks++;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_write%0d got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
    csr_read(A_STATUS, d);
    checks++;
    if (d[1] !== 1'b1 || d[23:8] !== 16'(m_pend.size())) begin
      errors++;
      $display("FAIL wrap_status got full=%b usedw=%0d want full=1 usedw=%0d", d[1], d[23:8], m_pend.size());
    end
    checks++;
    if (fifo_mem.size() != m_pend.size()) begin errors++; $display("FAIL wrap_fifo_left got %0d want %0d", fifo_mem.size(), m_pend.size()); end
    csr_write(A_RD_PTR, 32'd2);  m_rd = 2;
    model_drain(100);
    wait_writes();
    checks++;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap2_count got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap2_write%0d got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
    csr_read(A_WR_PTR, d);
    checks++;
    if (d !== 32'(m_wr)) begin errors++; $display("FAIL wrap_wr_ptr got %0d want %0d", d, m_wr); end
  endtask

  task automatic test_waitrequest();
    bit ok;
    logic [31:0] a0, d0;
    csr_write(A_RD_PTR, 32'(m_wr));  m_rd = m_wr;
    force_wait = 1'b1;
    push_word(FW'($urandom));
    push_word(FW'($urandom));
    model_drain(100);
    wait_write_req(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_req_seen got avm_write=0 want 1"); end
    a0 = avm_address;
    d0 = avm_writedata;
    checks++;
    if ({a0, d0} !== exp_q[0]) begin errors++; $display("FAIL wait_first got %h want %h", {a0, d0}, exp_q[0]); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (avm_write !== 1'b1 || avm_address !== a0 || avm_writedata !== d0 || fifo_rdreq !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold%0d got write=%b addr=%h data=%h rdreq=%b want 1 %h %h 0",
                 c, avm_write, avm_address, avm_writedata, fifo_rdreq, a0, d0);
      end
    end
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL wait_accepted got %0d want 0", act_q.size()); end
    force_wait = 1'b0;
    wait_writes();
    checks++;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL wait_count got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL wait_write%0d got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_irq();
    logic [31:0] d;
    soft_clear();
    csr_write(A_RD_PTR, 32'd0);     m_rd = 0;
    csr_write(A_LENGTH, 32'd8);     m_len = 8;
    csr_write(A_THRESHOLD, 32'd2);  m_thr = 2;
    csr_write(A_CTRL, 32'h3);       m_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push_word(FW'($urandom));
      model_drain(100);
      wait_writes();
      checks++;
      if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL irq_count%0d got %0d want %0d", k, act_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < act_q.size()) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL irq_write%0d got %h want %h", k, act_q[i], exp_q[i]); end
      end
      act_q.delete(); exp_q.delete();
      checks++;
      if (avs_csr_irq !== m_irq) begin errors++; $display("FAIL irq_line_after%0d got %b want %b", k + 1, avs_csr_irq, m_irq); end
    end
    csr_read(A_STATUS, d);
    checks++;
    if (d[2] !== m_irq) begin errors++; $display("FAIL irq_status got %b want %b", d[2], m_irq); end
    csr_write(A_STATUS, 32'h4);
    m_count = 0;
    m_irq = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (avs_csr_irq !== 1'b0) begin errors++; $display("FAIL irq_w1c_line got %b want 0", avs_csr_irq); end
    csr_read(A_COUNT, d);
    checks++;
    if (d !== 32'(m_count)) begin errors++; $display("FAIL irq_w1c_count got %0d want %0d", d, m_count); end
  endtask

  task automatic test_disable_clear();
    bit ok;
    logic [31:0] d;
    force_wait = 1'b1;
    push_word(FW'($urandom));
    push_word(FW'($urandom));
    model_drain(1);
    wait_write_req(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dis_req_seen got avm_write=0 want 1"); end
    csr_write(A_CTRL, 32'h0);
    m_en = 1'b0;
    force_wait = 1'b0;
    wait_writes();
    checks++;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL dis_count got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL dis_write%0d got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
    csr_read(A_STATUS, d);
    checks++;
    if (d[0] !== 1'b0) begin errors++; $display("FAIL dis_busy got %b want 0", d[0]); end
    checks++;
    if (fifo_mem.size() != m_pend.size()) begin errors++; $display("FAIL dis_fifo_left got %0d want %0d", fifo_mem.size(), m_pend.size()); end

    force_wait = 1'b1;
    csr_write(A_CTRL, 32'h1);
    m_en = 1'b1;
    model_drain(1);
    wait_write_req(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clr_req_seen got avm_write=0 want 1"); end
    csr_write(A_CTRL, 32'h5);
    csr_read(A_WR_PTR, d);
    checks++;
    if (d !== 32'((m_wr + m_len - 1) % m_len)) begin
      errors++;
      $display("FAIL clr_early got wr_ptr %0d want %0d", d, (m_wr + m_len - 1) % m_len);
    end
    force_wait = 1'b0;
    wait_writes();
    m_wr = 0;
    m_count = 0;
    m_irq = 1'b0;
    checks++;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL clr_count got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL clr_write%0d got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
    csr_read(A_WR_PTR, d);
    checks++;
    if (d !== 32'(m_wr)) begin errors++; $display("FAIL clr_wr_ptr got %0d want %0d", d, m_wr); end
    csr_read(A_COUNT, d);
    checks++;
    if (d !== 32'(m_count)) begin errors++; $display("FAIL clr_count_reg got %0d want %0d", d, m_count); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    int guard;
    rand_wait = 1'b1;
    for (int it = 0; it < 4; it++) begin
      soft_clear();
      m_base = $urandom & 32'hFFFF_FFFC;
      m_len = $urandom_range(2, 6);
      m_rd = 0;
      csr_write(A_BASE, $urandom & 32'hFFFF_FFFC | m_base & 32'hFFFF_FFFC);
      csr_write(A_BASE, m_base | 32'($urandom_range(0, 3)));
      csr_write(A_LENGTH, 32'(m_len));
      csr_write(A_RD_PTR, 32'd0);
      csr_write(A_CTRL, 32'h1);
      m_en = 1'b1;
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) push_word(FW'($urandom));
      guard = 0;
      while (guard < 12) begin
        model_drain(100);
        wait_writes();
        checks++;
        if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", it, act_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < act_q.size()) begin
          checks++;
          if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_write%0d got %h want %h", it, i, act_q[i], exp_q[i]); end
        end
        act_q.delete(); exp_q.delete();
        if (m_pend.size() == 0) break;
        csr_write(A_RD_PTR, 32'(m_wr));
        m_rd = m_wr;
        guard++;
      end
      csr_read(A_WR_PTR, d);
      checks++;
      if (d !== 32'(m_wr)) begin errors++; $display("FAIL rnd%0d_wr_ptr got %0d want %0d", it, d, m_wr); end
      csr_read(A_COUNT, d);
      checks++;
      if (d !== 32'(m_count)) begin errors++; $display("FAIL rnd%0d_count_reg got %0d want %0d", it, d, m_count); end
    end
    rand_wait = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [31:0] d;
    csr_write(A_RD_PTR, 32'(m_wr));
    force_wait = 1'b1;
    push_word(FW'($urandom));
    csr_write(A_CTRL, 32'h1);
    wait_write_req(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL areset_req_seen got avm_write=0 want 1"); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (avm_write !== 1'b0 || fifo_rdreq !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate got write=%b rdreq=%b want 0 0", avm_write, fifo_rdreq);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    force_wait = 1'b0;
    act_q.delete();
    m_pend.delete();
    for (int a = 0; a < 8; a++) begin
      csr_read(3'(a), d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL areset_csr%0d got %h want 0", a, d); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_wrap_full();
    test_waitrequest();
    test_irq();
    test_disable_clear();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
